// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY transmit lane driver.
// Line levels are packed as {Dp, Dn}.
package dphy_tx_pkg;

  typedef enum logic [2:0] {
    ST_STOP       = 3'd0,
    ST_HS_RQST    = 3'd1,
    ST_HS_PREPARE = 3'd2,
    ST_HS_ZERO    = 3'd3,
    ST_HS_SYNC    = 3'd4,
    ST_HS_DATA    = 3'd5,
    ST_HS_TRAIL   = 3'd6,
    ST_HS_EXIT    = 3'd7
  } dphy_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] hs_line(input logic b);
    return {b, ~b};
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/dphy_tx_serializer.sv
// 8-bit LSB-first load/shift register with bit index.
// Exposes both current and next-cycle bit/boundary for registered pads.
module dphy_tx_serializer
  import dphy_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_byte,
  output logic       o_bit,
  output logic       o_last,
  output logic       o_nbit,
  output logic       o_nlast
);

  logic [7:0] r_sr;
  logic [2:0] r_idx;
  logic [7:0] w_sr_n;
  logic [2:0] w_idx_n;

  always_comb begin
    w_sr_n  = r_sr;
    w_idx_n = r_idx;
    if (i_load) begin
      w_sr_n  = i_byte;
      w_idx_n = 3'd0;
    end else if (i_shift) begin
      w_sr_n  = {1'b0, r_sr[7:1]};
      w_idx_n = r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else begin
      r_sr  <= w_sr_n;
      r_idx <= w_idx_n;
    end
  end

  assign o_bit   = r_sr[0];
  assign o_last  = (r_idx == 3'd7);
  assign o_nbit  = w_sr_n[0];
  assign o_nlast = (w_idx_n == 3'd7);

endmodule

// File: rtl/dphy_tx_lane_driver.sv
// Single-lane MIPI D-PHY TX driver: LP/HS sequencing and serialization.
// Define DPHY_TX_MSB_FIRST_EN to send payload bytes MSB first.
module dphy_tx_lane_driver
  import dphy_tx_pkg::*;
#(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 4,
  parameter int T_HS_ZERO    = 8,
  parameter int T_HS_TRAIL   = 8,
  parameter int T_HS_EXIT    = 8
) (
  input  logic       TxDDRClkHS_I,
  input  logic       TxRst,
  input  logic       TxRequestHS,
  input  logic       TxValidHS,
  input  logic [7:0] TxDataHS,
  input  logic       TxLP_Enable,
  output logic       TxDp,
  output logic       TxDn,
  output logic       TxClk_Enable,
  output logic [2:0] DphyTxState,
  output logic       TxReadyHS
);

  localparam int T_MAX = max2(max2(max2(T_LPX, T_HS_PREPARE),
                                   max2(T_HS_ZERO, T_HS_TRAIL)),
                              T_HS_EXIT);
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_LPX   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] C_PREP  = CW'(T_HS_PREPARE - 1);
  localparam logic [CW-1:0] C_ZERO  = CW'(T_HS_ZERO - 1);
  localparam logic [CW-1:0] C_TRAIL = CW'(T_HS_TRAIL - 1);
  localparam logic [CW-1:0] C_EXIT  = CW'(T_HS_EXIT - 1);

  dphy_state_e   r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic          r_trail, w_ntrail;
  logic [1:0]    r_line, w_nline;
  logic          r_rdy, w_nrdy;
  logic          r_ce, w_nce;

  logic       w_bit, w_last, w_nbit, w_nlast;
  logic       w_hs_tx, w_take, w_sync_ld, w_load, w_shift;
  logic [7:0] w_data, w_byte;

`ifdef DPHY_TX_MSB_FIRST_EN
  assign w_data = bit_rev8(TxDataHS);
`else
  assign w_data = TxDataHS;
`endif

  assign w_hs_tx   = (r_state == ST_HS_SYNC) || (r_state == ST_HS_DATA);
  assign w_take    = w_hs_tx && w_last && TxValidHS && TxRequestHS;
  assign w_sync_ld = (r_state == ST_HS_ZERO) && (r_cnt == C_ZERO);
  assign w_load    = w_sync_ld || w_take;
  assign w_shift   = w_hs_tx && !w_last;
  assign w_byte    = w_sync_ld ? SYNC_BYTE : w_data;

  dphy_tx_serializer u_ser (
    .clk     (TxDDRClkHS_I),
    .rst_n   (TxRst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_byte  (w_byte),
    .o_bit   (w_bit),
    .o_last  (w_last),
    .o_nbit  (w_nbit),
    .o_nlast (w_nlast)
  );

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + C_ONE;
    w_ntrail = r_trail;
    unique case (r_state)
      ST_STOP: begin
        w_ncnt = '0;
        if (TxRequestHS && TxLP_Enable) w_nstate = ST_HS_RQST;
      end
      ST_HS_RQST:
        if (r_cnt == C_LPX) begin
          w_nstate = ST_HS_PREPARE;
          w_ncnt   = '0;
        end
      ST_HS_PREPARE:
        if (r_cnt == C_PREP) begin
          w_nstate = ST_HS_ZERO;
          w_ncnt   = '0;
        end
      ST_HS_ZERO:
        if (r_cnt == C_ZERO) begin
          w_nstate = ST_HS_SYNC;
          w_ncnt   = '0;
        end
      ST_HS_SYNC, ST_HS_DATA: begin
        w_ncnt = '0;
        if (w_take) begin
          w_nstate = ST_HS_DATA;
        end else if (w_last) begin
          w_nstate = ST_HS_TRAIL;
          w_ntrail = ~w_bit;
        end
      end
      ST_HS_TRAIL:
        if (r_cnt == C_TRAIL) begin
          w_nstate = ST_HS_EXIT;
          w_ncnt   = '0;
        end
      ST_HS_EXIT:
        if (r_cnt == C_EXIT) begin
          w_nstate = ST_STOP;
          w_ncnt   = '0;
        end
    endcase
  end

  // Pad values are computed for the next state so every output is a flop
  always_comb begin
    w_nline = LP11;
    w_nce   = 1'b1;
    w_nrdy  = 1'b0;
    unique case (w_nstate)
      ST_STOP: begin
        w_nce   = 1'b0;
        w_nline = TxLP_Enable ? LP11 : LP00;
      end
      ST_HS_RQST:    w_nline = LP01;
      ST_HS_PREPARE: w_nline = LP00;
      ST_HS_ZERO:    w_nline = hs_line(1'b0);
      ST_HS_SYNC, ST_HS_DATA: begin
        w_nline = hs_line(w_nbit);
        w_nrdy  = w_nlast;
      end
      ST_HS_TRAIL:   w_nline = hs_line(w_ntrail);
      ST_HS_EXIT: begin
        w_nce   = 1'b0;
        w_nline = LP11;
      end
    endcase
  end

  always_ff @(posedge TxDDRClkHS_I or negedge TxRst) begin
    if (!TxRst) begin
      r_state <= ST_STOP;
      r_cnt   <= '0;
      r_trail <= 1'b0;
      r_line  <= LP11;
      r_rdy   <= 1'b0;
      r_ce    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_trail <= w_ntrail;
      r_line  <= w_nline;
      r_rdy   <= w_nrdy;
      r_ce    <= w_nce;
    end
  end

  assign TxDp         = r_line[1];
  assign TxDn         = r_line[0];
  assign TxClk_Enable = r_ce;
  assign TxReadyHS    = r_rdy;
  assign DphyTxState  = r_state;

endmodule

// File: tb/tb_dphy_tx_lane_driver.sv
// Scoreboard bench for dphy_tx_lane_driver: per-cycle pad expectations
// plus a byte-level payload queue, checked by an independent monitor.
module tb_dphy_tx_lane_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       vld = 1'b0;
  logic       lpen = 1'b1;
  logic [7:0] data = 8'h00;
  logic       dp, dn, ce, rdy;
  logic [2:0] st;

  dphy_tx_lane_driver dut (
    .TxDDRClkHS_I (clk),
    .TxRst        (rst_n),
    .TxRequestHS  (req),
    .TxValidHS    (vld),
    .TxDataHS     (data),
    .TxLP_Enable  (lpen),
    .TxDp         (dp),
    .TxDn         (dn),
    .TxClk_Enable (ce),
    .DphyTxState  (st),
    .TxReadyHS    (rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] line;
    logic [2:0] st;
    logic       rdy;
    logic       ce;
  } exp_t;

  exp_t       q[$];
  logic [7:0] bq[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic push(input int c, input logic [1:0] l, input logic [2:0] s,
                      input logic r, input logic e);
    exp_t x;
    x.c = c; x.line = l; x.st = s; x.rdy = r; x.ce = e;
    q.push_back(x);
  endtask

  task automatic push_entry(input int b);
    logic [7:0] s;
    s = 8'hB8;
    for (int i = 0; i < 4; i++) push(b + i, 2'b01, 3'd1, 1'b0, 1'b1);
    for (int i = 4; i < 8; i++) push(b + i, 2'b00, 3'd2, 1'b0, 1'b1);
    for (int i = 8; i < 16; i++) push(b + i, 2'b01, 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      push(b + 16 + i, {s[i], ~s[i]}, 3'd4, i == 7, 1'b1);
  endtask

  task automatic push_byte(input int b, input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      push(b + i, {v[i], ~v[i]}, 3'd5, i == 7, 1'b1);
    bq.push_back(v);
  endtask

  task automatic push_tail(input int b, input logic [1:0] tl);
    for (int i = 0; i < 8; i++) push(b + i, tl, 3'd6, 1'b0, 1'b1);
    for (int i = 8; i < 16; i++) push(b + i, 2'b11, 3'd7, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle scoreboard and payload byte reassembly
  exp_t       mx;
  int         nb = 0;
  logic [7:0] acc;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      mx = q.pop_front();
      chk("slot_missed", cyc, mx.c);
    end
    while (q.size() > 0 && q[0].c == cyc) begin
      mx = q.pop_front();
      chk("line", {dp, dn}, mx.line);
      chk("state", st, mx.st);
      chk("ready", rdy, mx.rdy);
      chk("clk_en", ce, mx.ce);
    end
    if (rst_n && st == 3'd5) begin
      acc[nb] = dp;
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (bq.size() == 0) chk("byte_unexpected", acc, 0);
        else chk("byte", acc, bq.pop_front());
      end
    end else begin
      nb = 0;
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] bytes [5] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h7E};
  int c0;

  initial begin
    c0 = 16;
    for (int i = 2; i < 10; i++) push(i, 2'b11, 3'd0, 1'b0, 1'b0);
    for (int i = 11; i < 15; i++) push(i, 2'b11, 3'd0, 1'b0, 1'b0);
    push_entry(c0 + 1);
    for (int j = 0; j < 5; j++) push_byte(c0 + 25 + 8 * j, bytes[j]);
    push_tail(c0 + 65, 2'b10);
    push(c0 + 81, 2'b11, 3'd0, 1'b0, 1'b0);
    push_entry(c0 + 82);
    push(c0 + 106, 2'b01, 3'd5, 1'b0, 1'b1);
    push(c0 + 107, 2'b10, 3'd5, 1'b0, 1'b1);
    for (int i = 109; i < 112; i++) push(c0 + i, 2'b11, 3'd0, 1'b0, 1'b0);
    for (int i = 112; i < 117; i++) push(c0 + i, 2'b00, 3'd0, 1'b0, 1'b0);
    push_entry(c0 + 117);
    push_tail(c0 + 141, 2'b01);
    push(c0 + 157, 2'b11, 3'd0, 1'b0, 1'b0);
    push(c0 + 158, 2'b11, 3'd0, 1'b0, 1'b0);

    at(10);
    rst_n = 1'b1;

    at(c0);
    req = 1'b1; vld = 1'b1; data = 8'hA5;
    for (int k = 1; k <= 64; k++) begin
      at(c0 + k);
      if (k >= 24 && (k - 24) % 8 == 0) begin
        if ((k - 24) / 8 < 5) begin
          data = bytes[(k - 24) / 8];
        end else begin
          vld = 1'b0;
          data = 8'h00;
        end
      end else begin
        data = 8'(k * 37);
      end
    end
    at(c0 + 70);
    vld = 1'b1;
    at(c0 + 105);
    data = 8'h96;
    at(c0 + 106);
    data = 8'h00;
    at(c0 + 108);
    rst_n = 1'b0;
    at(c0 + 111);
    rst_n = 1'b1;
    lpen = 1'b0;
    at(c0 + 116);
    lpen = 1'b1;
    at(c0 + 140);
    req = 1'b0;
    at(c0 + 162);

    chk("exp_queue_drained", q.size(), 0);
    chk("byte_queue_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
